// File: rtl/mod_74x32_bank_bist_if.sv
// Bus bundle for the registered two-input gate bank with built-in self-test.
// The master drives operands, function select and BIST requests; the slave returns results and status.
interface mod_74x32_bank_bist_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             inj;
  logic [WIDTH-1:0] y;
  logic             bist_start;
  logic             bist_busy;
  logic             bist_done;
  logic             bist_pass;
  logic [1:0]       bist_fail_idx;

  modport master (
    output a, b, op, inj, bist_start,
    input  y, bist_busy, bist_done, bist_pass, bist_fail_idx
  );

  modport slave (
    input  a, b, op, inj, bist_start,
    output y, bist_busy, bist_done, bist_pass, bist_fail_idx
  );
endinterface

// File: rtl/mod_74x32_bank_bist.sv
// WIDTH-channel OR/NOR/AND/XOR gate bank with LAT registered stages and a hardware
// self-test that pushes the four truth-table vectors through the same pipeline.
module mod_74x32_bank_bist #(
  parameter int WIDTH = 4,
  parameter int LAT   = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  mod_74x32_bank_bist_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] DRAIN_LAST = 2'(LAT - 1);

  function automatic logic [WIDTH-1:0] gate_f(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] res;
    case (op)
      2'b00:   res = a | b;
      2'b01:   res = ~(a | b);
      2'b10:   res = a & b;
      default: res = a ^ b;
    endcase
    return res;
  endfunction

  // Vector k: A is all-ones for k0/k1, B is all-ones for k0/k2.
  function automatic logic [WIDTH-1:0] vec_a(input logic [1:0] k);
    return {WIDTH{~k[1]}};
  endfunction

  function automatic logic [WIDTH-1:0] vec_b(input logic [1:0] k);
    return {WIDTH{~k[0]}};
  endfunction

  state_t           state;
  logic [1:0]       k_cnt;
  logic [1:0]       drain_cnt;
  logic [1:0]       op_bist;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [1:0]       fail_idx_q;
  logic             fail_seen;
  logic [1:0]       first_idx;

  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [1:0]       sel_op;
  logic             ins_bist;
  logic             bubble;
  logic [WIDTH-1:0] inj_mask;
  logic [WIDTH-1:0] r_p0;

  logic [WIDTH-1:0] data_p [LAT];
  logic             vld_p  [LAT];
  logic [1:0]       k_p    [LAT];

  logic [WIDTH-1:0] exp_out;
  logic             mismatch;

  // Input selection: external operands in IDLE/DONE, forced vectors in RUN, bubbles in DRAIN.
  always_comb begin
    sel_a    = bus.a;
    sel_b    = bus.b;
    sel_op   = bus.op;
    ins_bist = 1'b0;
    bubble   = 1'b0;
    case (state)
      ST_RUN: begin
        sel_a    = vec_a(k_cnt);
        sel_b    = vec_b(k_cnt);
        sel_op   = op_bist;
        ins_bist = 1'b1;
      end
      ST_DRAIN: bubble = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    inj_mask    = '0;
    inj_mask[0] = bus.inj;
  end

  assign r_p0 = bubble ? '0 : (gate_f(sel_op, sel_a, sel_b) ^ inj_mask);

  // Stage 0 .. LAT-1: result, BIST tag and vector index shift together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        data_p[i] <= '0;
        vld_p[i]  <= 1'b0;
        k_p[i]    <= 2'd0;
      end
    end else begin
      data_p[0] <= r_p0;
      vld_p[0]  <= ins_bist;
      k_p[0]    <= k_cnt;
      for (int i = 1; i < LAT; i++) begin
        data_p[i] <= data_p[i-1];
        vld_p[i]  <= vld_p[i-1];
        k_p[i]    <= k_p[i-1];
      end
    end
  end

  // Expected value ignores INJ so an injected fault is always caught.
  assign exp_out  = gate_f(op_bist, vec_a(k_p[LAT-1]), vec_b(k_p[LAT-1]));
  assign mismatch = vld_p[LAT-1] && (data_p[LAT-1] != exp_out);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      k_cnt      <= 2'd0;
      drain_cnt  <= 2'd0;
      op_bist    <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_idx_q <= 2'd0;
      fail_seen  <= 1'b0;
      first_idx  <= 2'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.bist_start) begin
            state      <= ST_RUN;
            op_bist    <= bus.op;
            pass_q     <= 1'b0;
            fail_idx_q <= 2'd0;
            fail_seen  <= 1'b0;
            first_idx  <= 2'd0;
            k_cnt      <= 2'd0;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          k_cnt <= k_cnt + 2'd1;
          if (k_cnt == 2'd3) begin
            state     <= ST_DRAIN;
            drain_cnt <= 2'd0;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_cnt == DRAIN_LAST) begin
            // The last vector is exiting now, so fold in this cycle's compare too.
            state      <= ST_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            pass_q     <= !(fail_seen || mismatch);
            fail_idx_q <= fail_seen ? first_idx : (mismatch ? k_p[LAT-1] : 2'd0);
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (mismatch && !fail_seen) begin
        fail_seen <= 1'b1;
        first_idx <= k_p[LAT-1];
      end
    end
  end

  assign bus.y             = data_p[LAT-1];
  assign bus.bist_busy     = busy_q;
  assign bus.bist_done     = done_q;
  assign bus.bist_pass     = pass_q;
  assign bus.bist_fail_idx = fail_idx_q;

endmodule

// File: tb/tb_mod_74x32_bank_bist.sv
// Directed bench for the gate bank: four instances (W4/L1, W4/L3, W1/L4, W32/L4) share stimulus.
module tb_mod_74x32_bank_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] a_drv;
  logic [31:0] b_drv;
  logic [1:0]  op_drv;
  logic        inj_drv;
  logic        start_drv;

  int checks = 0;
  int errors = 0;

  localparam int LAT_V [4] = '{1, 3, 4, 4};

  mod_74x32_bank_bist_if #(.WIDTH(4))  if0 ();
  mod_74x32_bank_bist_if #(.WIDTH(4))  if1 ();
  mod_74x32_bank_bist_if #(.WIDTH(1))  if2 ();
  mod_74x32_bank_bist_if #(.WIDTH(32)) if3 ();

  assign if0.a = a_drv[3:0];  assign if0.b = b_drv[3:0];
  assign if1.a = a_drv[3:0];  assign if1.b = b_drv[3:0];
  assign if2.a = a_drv[0:0];  assign if2.b = b_drv[0:0];
  assign if3.a = a_drv;       assign if3.b = b_drv;
  assign if0.op = op_drv;  assign if1.op = op_drv;  assign if2.op = op_drv;  assign if3.op = op_drv;
  assign if0.inj = inj_drv;  assign if1.inj = inj_drv;  assign if2.inj = inj_drv;  assign if3.inj = inj_drv;
  assign if0.bist_start = start_drv;  assign if1.bist_start = start_drv;
  assign if2.bist_start = start_drv;  assign if3.bist_start = start_drv;

  mod_74x32_bank_bist #(.WIDTH(4),  .LAT(1)) u_w4_l1  (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  mod_74x32_bank_bist #(.WIDTH(4),  .LAT(3)) u_w4_l3  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  mod_74x32_bank_bist #(.WIDTH(1),  .LAT(4)) u_w1_l4  (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  mod_74x32_bank_bist #(.WIDTH(32), .LAT(4)) u_w32_l4 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  logic [31:0] y_v   [4];
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [3:0]  pass_v;
  logic [1:0]  fidx_v [4];

  assign y_v[0] = {28'd0, if0.y};
  assign y_v[1] = {28'd0, if1.y};
  assign y_v[2] = {31'd0, if2.y};
  assign y_v[3] = if3.y;
  assign busy_v = {if3.bist_busy, if2.bist_busy, if1.bist_busy, if0.bist_busy};
  assign done_v = {if3.bist_done, if2.bist_done, if1.bist_done, if0.bist_done};
  assign pass_v = {if3.bist_pass, if2.bist_pass, if1.bist_pass, if0.bist_pass};
  assign fidx_v[0] = if0.bist_fail_idx;
  assign fidx_v[1] = if1.bist_fail_idx;
  assign fidx_v[2] = if2.bist_fail_idx;
  assign fidx_v[3] = if3.bist_fail_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_flags(input string tag, input logic exp_pass);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_busy[%0d]", tag, d), 32'(busy_v[d]), 32'd0);
      check($sformatf("%s_done[%0d]", tag, d), 32'(done_v[d]), 32'd0);
      check($sformatf("%s_pass[%0d]", tag, d), 32'(pass_v[d]), 32'(exp_pass));
      check($sformatf("%s_fidx[%0d]", tag, d), 32'(fidx_v[d]), 32'd0);
    end
  endtask

  // One BIST sweep on all instances; external A/B/OP are scrambled mid-run to prove they are ignored.
  task automatic run_bist(input logic [1:0] opv, input logic injv, input logic exp_pass,
                          input logic [1:0] exp_fidx, input logic [31:0] k0_y4,
                          input logic [31:0] k0_y32);
    int   busy_cnt [4];
    int   done_at  [4];
    int   done_num [4];
    logic pass_at  [4];
    logic [1:0] fidx_at [4];
    for (int d = 0; d < 4; d++) begin
      busy_cnt[d] = 0; done_at[d] = 0; done_num[d] = 0; pass_at[d] = 1'b0; fidx_at[d] = 2'd0;
    end
    a_drv = 32'h5; b_drv = 32'h3; op_drv = opv; inj_drv = injv; start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      for (int d = 0; d < 4; d++) begin
        if (busy_v[d]) busy_cnt[d]++;
        if (done_v[d]) begin
          done_num[d]++; done_at[d] = c; pass_at[d] = pass_v[d]; fidx_at[d] = fidx_v[d];
        end
      end
      if (c == 2) check("k0_y_w4_l1", y_v[0], k0_y4);
      if (c == 5) check("k0_y_w32_l4", y_v[3], k0_y32);
      if (c == 3) begin op_drv = ~opv; a_drv = 32'hA5A5_A5A5; b_drv = 32'h0F0F_0F0F; end
      tick();
    end
    for (int d = 0; d < 4; d++) begin
      check($sformatf("busy_cycles[%0d] op%0d", d, opv), busy_cnt[d], 32'(4 + LAT_V[d]));
      check($sformatf("done_cycle[%0d] op%0d", d, opv), done_at[d], 32'(5 + LAT_V[d]));
      check($sformatf("done_pulses[%0d] op%0d", d, opv), done_num[d], 32'd1);
      check($sformatf("pass[%0d] op%0d", d, opv), 32'(pass_at[d]), 32'(exp_pass));
      check($sformatf("fidx[%0d] op%0d", d, opv), 32'(fidx_at[d]), 32'(exp_fidx));
      check($sformatf("pass_held[%0d] op%0d", d, opv), 32'(pass_v[d]), 32'(exp_pass));
    end
    inj_drv = 1'b0;
  endtask

  logic [31:0] exp_tab [4][4];
  int done_tot [4];

  initial begin
    exp_tab[0] = '{32'hE, 32'h1, 32'h8, 32'h6};
    exp_tab[1] = '{32'hE, 32'h1, 32'h8, 32'h6};
    exp_tab[2] = '{32'h0, 32'h1, 32'h0, 32'h0};
    exp_tab[3] = '{32'hE, 32'hFFFF_FFF1, 32'h8, 32'h6};

    // Reset holds everything at zero even with live operands.
    rst_n = 1'b0; a_drv = 32'hF; b_drv = 32'h0; op_drv = 2'b00; inj_drv = 1'b0; start_drv = 1'b0;
    tick(); tick();
    for (int d = 0; d < 4; d++) check($sformatf("rst_y[%0d]", d), y_v[d], 32'd0);
    check_idle_flags("rst", 1'b0);

    rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      for (int d = 0; d < 4; d++)
        check($sformatf("rel_y[%0d] c%0d", d, c), y_v[d],
              (c >= LAT_V[d]) ? ((d == 2) ? 32'h1 : 32'hF) : 32'h0);
    end

    // Function select stepped every cycle; each OP follows its own sample.
    a_drv = 32'hC; b_drv = 32'hA;
    for (int i = 0; i <= 5; i++) begin
      op_drv = (i > 3) ? 2'd3 : 2'(i);
      tick();
      for (int d = 0; d < 4; d++) begin
        int j;
        j = i - (LAT_V[d] - 1);
        if (j >= 0) begin
          if (j > 3) j = 3;
          check($sformatf("func_y[%0d] i%0d", d, i), y_v[d], exp_tab[d][j]);
        end
      end
    end

    // Clean sweeps for every function, then an injected fault.
    run_bist(2'b00, 1'b0, 1'b1, 2'd0, 32'hF, 32'hFFFF_FFFF);
    run_bist(2'b01, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);
    run_bist(2'b10, 1'b0, 1'b1, 2'd0, 32'hF, 32'hFFFF_FFFF);
    run_bist(2'b11, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);
    run_bist(2'b00, 1'b1, 1'b0, 2'd0, 32'hE, 32'hFFFF_FFFE);
    run_bist(2'b10, 1'b0, 1'b1, 2'd0, 32'hF, 32'hFFFF_FFFF);

    // Reset in cycle 3 of a sweep aborts it with no DONE and clears PASS.
    op_drv = 2'b10; start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_idle_flags("abort", 1'b0);
    rst_n = 1'b1;
    for (int d = 0; d < 4; d++) done_tot[d] = 0;
    for (int c = 1; c <= 14; c++) begin
      for (int d = 0; d < 4; d++) if (done_v[d]) done_tot[d]++;
      tick();
    end
    for (int d = 0; d < 4; d++) begin
      check($sformatf("abort_no_done[%0d]", d), done_tot[d], 32'd0);
      check($sformatf("abort_pass[%0d]", d), 32'(pass_v[d]), 32'd0);
    end

    // A second START while busy is dropped: one DONE per instance.
    op_drv = 2'b11; start_drv = 1'b1;
    tick();
    for (int d = 0; d < 4; d++) done_tot[d] = 0;
    for (int c = 1; c <= 16; c++) begin
      start_drv = (c == 3);
      for (int d = 0; d < 4; d++) if (done_v[d]) done_tot[d]++;
      tick();
    end
    start_drv = 1'b0;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("repulse_done[%0d]", d), done_tot[d], 32'd1);
      check($sformatf("repulse_pass[%0d]", d), 32'(pass_v[d]), 32'd1);
      check($sformatf("repulse_busy[%0d]", d), 32'(busy_v[d]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
